// File: rtl/async_transmitter_fifo_pkg.sv
// Shared UART definitions: transmitter FSM encoding, parity modes, baud increment
// and parity helpers. Used by the transmitter, its baud generator and the receiver.
package async_transmitter_fifo_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } tx_state_e;

  localparam logic [1:0] PARITY_EVEN  = 2'd0;
  localparam logic [1:0] PARITY_ODD   = 2'd1;
  localparam logic [1:0] PARITY_MARK  = 2'd2;
  localparam logic [1:0] PARITY_SPACE = 2'd3;

  // Fractional accumulator increment; the >>4/>>5 terms keep the product in range
  // and round to nearest.
  function automatic int unsigned baud_inc(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned acc_w,
                                           input longint unsigned oversample);
    longint unsigned num;
    num = ((baud * oversample) << (acc_w - 64'd4)) + (clk_hz >> 5);
    return 32'(num / (clk_hz >> 4));
  endfunction

  function automatic logic parity_bit(input logic [1:0] mode, input logic [DATA_W-1:0] data);
    logic p;
    case (mode)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~^data;
      PARITY_MARK: p = 1'b1;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/async_transmitter_fifo_if.sv
// Write-side handshake and line status of the UART transmitter.
//  master: control logic (drives TxD_start/TxD_data, observes status and line)
//  slave : transmitter   (drives TxD_ready, TxD_busy, TxD_fifo_level, TxD)
interface async_transmitter_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             TxD_start;
  logic [7:0]       TxD_data;
  logic             TxD_ready;
  logic             TxD_busy;
  logic [LVL_W-1:0] TxD_fifo_level;
  logic             TxD;

  modport master (
    output TxD_start, TxD_data,
    input  TxD_ready, TxD_busy, TxD_fifo_level, TxD
  );

  modport slave (
    input  TxD_start, TxD_data,
    output TxD_ready, TxD_busy, TxD_fifo_level, TxD
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running fractional baud generator; tick_o pulses once per bit period
// (or once per 1/Oversample of a bit period).
//  clk, rst : clock, async active-high reset
//  tick_o   : single-cycle tick, taken straight from the accumulator carry register
module uart_baud_tick
  import async_transmitter_fifo_pkg::*;
#(
  parameter int unsigned ClkFrequency = 24000000,
  parameter int unsigned Baud         = 57600,
  parameter int unsigned AccWidth     = 16,
  parameter int unsigned Oversample   = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned Inc = baud_inc(64'(ClkFrequency), 64'(Baud),
                                         64'(AccWidth), 64'(Oversample));

  logic [AccWidth:0] acc_q, acc_d;

  // Carry out of the previous add is dropped before the next add.
  always_comb begin
    acc_d = {1'b0, acc_q[AccWidth-1:0]} + (AccWidth+1)'(Inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign tick_o = acc_q[AccWidth];

endmodule

// File: rtl/async_transmitter_fifo.sv
// RS-232 transmitter with a small write FIFO. Each byte goes out as
// start(0), D0..D7 LSB first, parity, STOP_BITS x stop(1); queued bytes follow
// back-to-back with no idle bit.
//  clk, rst            : clock, async active-high reset (truncates a frame, flushes FIFO)
//  tx.TxD_start/Data   : write strobe/byte, accepted when TxD_ready is high
//  tx.TxD_ready        : FIFO not full
//  tx.TxD_busy         : frame in flight or bytes queued
//  tx.TxD_fifo_level   : bytes queued, excluding the one being shifted
//  tx.TxD              : serial line, idle high
module async_transmitter_fifo
  import async_transmitter_fifo_pkg::*;
#(
  parameter int unsigned ClkFrequency    = 24000000,
  parameter int unsigned Baud            = 57600,
  parameter int unsigned BaudGenAccWidth = 16,
  parameter int unsigned PARITY_MODE     = 0,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  async_transmitter_fifo_if.slave  tx
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic tick;

  tx_state_e          state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic               push, pop;
  logic [DATA_W-1:0]  head;

  uart_baud_tick #(
    .ClkFrequency (ClkFrequency),
    .Baud         (Baud),
    .AccWidth     (BaudGenAccWidth),
    .Oversample   (1)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Ready comes from the registered level, so a same-cycle pop never admits a write while full.
  assign push = tx.TxD_start && ready_q;
  assign head = mem_q[rd_q[AW-1:0]];

  // Next-state for FSM, shifter, pointers and registered outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    txd_d     = txd_q;
    pop       = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          txd_d = 1'b1;
          if (level_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
            txd_d   = 1'b0;
          end
        end
        S_START: begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
        end
        S_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
            txd_d   = par_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP1;
          txd_d   = 1'b1;
        end
        S_STOP1, S_STOP2: begin
          if (state_q == S_STOP1 && STOP_BITS == 2) begin
            state_d = S_STOP2;
            txd_d   = 1'b1;
          end else if (level_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end

    // Parity is fixed from the popped byte, independent of the shifting copy.
    if (pop) begin
      shift_d = head;
      par_d   = parity_bit(2'(PARITY_MODE), head);
    end

    wr_d    = push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = pop  ? rd_q + (AW+1)'(1) : rd_q;
    level_d = LVL_W'(wr_d - rd_d);
    ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    busy_d  = (state_d != S_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= tx.TxD_data;
  end

  assign tx.TxD            = txd_q;
  assign tx.TxD_busy       = busy_q;
  assign tx.TxD_ready      = ready_q;
  assign tx.TxD_fifo_level = level_q;

endmodule
